alu_issue_ctrl: RTL



---
 rtl/alu_issue_ctrl_if.sv | 26 ++
 rtl/alu_issue_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake, ALU port and external I/O bundle of the issue controller.
// The master side is the controller; the slave side is its environment.
interface alu_issue_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [7:0]  alu_opcode;
  logic [7:0]  alu_in1;
  logic [7:0]  alu_in2;
  logic [7:0]  alu_result;
  logic [7:0]  io_in;
  logic [7:0]  io_out;
  logic        io_out_valid;
  logic        busy;
  logic        illegal;

  modport master (
    input  instr_valid, instr, alu_result, io_in,
    output instr_ready, alu_opcode, alu_in1, alu_in2, io_out, io_out_valid, busy, illegal
  );

  modport slave (
    output instr_valid, instr, alu_result, io_in,
    input  instr_ready, alu_opcode, alu_in1, alu_in2, io_out, io_out_valid, busy, illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for an 8-bit combinational ALU: one instruction every
// four cycles through IDLE -> READ -> EXEC -> WB, with a small internal register file.
module alu_issue_ctrl #(
  parameter int         NUM_REGS    = 6,
  parameter logic [7:0] IDLE_OPCODE = 8'h20
) (
  input logic           clk,
  input logic           rst,
  alu_issue_ctrl_if.master bus
);

  localparam logic [2:0] IO_ADDR = 3'd6;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t     state, state_nx;
  logic       accept;

  logic [7:0] opc_p0, arg1_p0, arg2_p0;
  logic [2:0] dest_p0;
  logic [7:0] rd1, rd2;
  logic [7:0] op1, op2;
  logic [7:0] result_p2;
  logic [7:0] regs [NUM_REGS];

  // Address 6 is the input port, 7 reads as zero (rd defaults to 0 for it).
  function automatic logic [7:0] pick(input logic imm, input logic [7:0] a,
                                      input logic [7:0] rd, input logic [7:0] io);
    if (imm) return a;
    if (a[2:0] == IO_ADDR) return io;
    return rd;
  endfunction

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (arg1_p0[2:0] == 3'(i)) rd1 = regs[i];
      if (arg2_p0[2:0] == 3'(i)) rd2 = regs[i];
    end
    op1 = pick(opc_p0[7], arg1_p0, rd1, bus.io_in);
    op2 = pick(opc_p0[6], arg2_p0, rd2, bus.io_in);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A rejected instruction skips READ/EXEC and spends its single busy cycle in WB.
  always_comb begin
    state_nx        = state;
    accept          = 1'b0;
    bus.instr_ready = 1'b0;
    bus.busy        = 1'b1;
    case (state)
      IDLE: begin
        bus.instr_ready = 1'b1;
        bus.busy        = 1'b0;
        accept          = bus.instr_valid;
        if (bus.instr_valid) state_nx = bus.instr[29] ? WB : READ;
      end
      READ:    state_nx = EXEC;
      EXEC:    state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opc_p0           <= '0;
      arg1_p0          <= '0;
      arg2_p0          <= '0;
      dest_p0          <= '0;
      result_p2        <= '0;
      bus.alu_opcode   <= IDLE_OPCODE;
      bus.alu_in1      <= '0;
      bus.alu_in2      <= '0;
      bus.io_out       <= '0;
      bus.io_out_valid <= 1'b0;
      bus.illegal      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      bus.alu_opcode   <= IDLE_OPCODE;
      bus.alu_in1      <= '0;
      bus.alu_in2      <= '0;
      bus.io_out_valid <= 1'b0;
      bus.illegal      <= 1'b0;

      // p0: instruction fields captured on accept
      if (accept) begin
        opc_p0      <= bus.instr[31:24];
        arg1_p0     <= bus.instr[23:16];
        arg2_p0     <= bus.instr[15:8];
        dest_p0     <= bus.instr[2:0];
        bus.illegal <= bus.instr[29];
      end

      // p1: operands resolved in READ drive the ALU for exactly the EXEC cycle
      if (state == READ) begin
        bus.alu_opcode <= {3'b000, opc_p0[4:0]};
        bus.alu_in1    <= op1;
        bus.alu_in2    <= op2;
      end

      // p2: ALU result captured at the end of EXEC
      if (state == EXEC) result_p2 <= bus.alu_result;

      if (state == WB && !opc_p0[5]) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (dest_p0 == 3'(i)) regs[i] <= result_p2;
        if (dest_p0 == IO_ADDR) begin
          bus.io_out       <= result_p2;
          bus.io_out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
